// File: rtl/display_pkg.sv
// display_pkg: shared constants and types for the display scan controller
package display_pkg;
   localparam int   DIGITS_MAX = 8;
   localparam logic SEG_OFF    = 1'b1;
   localparam logic AN_OFF     = 1'b1;
   typedef logic [3:0] nibble_t;
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: per-digit slot counter with blanking/drive phase strobes
//   clk, rst_n  : clock, synchronous active-low reset
//   slot_start  : counter is at the first cycle of a slot
//   slot_end    : counter is at the last cycle of a slot
//   drive_en    : counter is past the blanking interval
module scan_prescaler #(
   parameter int PRESCALE  = 5000,
   parameter int BLANK_CYC = 64
) (
   input  logic clk,
   input  logic rst_n,
   output logic slot_start,
   output logic slot_end,
   output logic drive_en
);
   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK = CW'(BLANK_CYC);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
   assign slot_start = cnt_q == '0;
   assign slot_end   = cnt_q == LAST;
   assign drive_en   = cnt_q >= BLANK;
endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexed scan controller for a common-anode 7-segment display
//   clk, rst_n  : clock, synchronous active-low reset
//   value       : display value, digit i shows value[4i+3:4i]
//   digit_en    : per-digit enable, dp_in : per-digit decimal point
//   nibble      : current digit value for the downstream decoder
//   digit, dp   : active-low anodes and decimal point
//   frame_tick  : one-cycle pulse when a new snapshot is taken
module display_scan
   import display_pkg::*;
#(
   parameter int NDIG      = 8,
   parameter int PRESCALE  = 5000,
   parameter int BLANK_CYC = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     value,
   input  logic [NDIG-1:0] digit_en,
   input  logic [NDIG-1:0] dp_in,
   output logic [3:0]      nibble,
   output logic [NDIG-1:0] digit,
   output logic            dp,
   output logic            frame_tick
);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
   logic slot_start, slot_end, drive_en, snap;
   logic [IW-1:0] idx_q, idx_d;
   nibble_t [NDIG-1:0] sh_val_q, sh_val_d;
   logic [NDIG-1:0] sh_en_q, sh_en_d, sh_dp_q, sh_dp_d, digit_q, digit_d;
   nibble_t nibble_q, nibble_d;
   logic dp_q, dp_d, tick_q;
   scan_prescaler #(.PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) u_pre (
      .clk        (clk),
      .rst_n      (rst_n),
      .slot_start (slot_start),
      .slot_end   (slot_end),
      .drive_en   (drive_en)
   );
   // Outputs are computed from the post-snapshot shadow so the first slot of a
   // frame already shows the freshly captured inputs.
   always_comb begin
      snap     = slot_start && (idx_q == '0);
      sh_val_d = snap ? value[4*NDIG-1:0] : sh_val_q;
      sh_en_d  = snap ? digit_en : sh_en_q;
      sh_dp_d  = snap ? dp_in : sh_dp_q;
      idx_d    = slot_end ? ((idx_q == IDX_LAST) ? '0 : idx_q + IW'(1)) : idx_q;
      nibble_d = sh_val_d[idx_q];
      digit_d  = {NDIG{AN_OFF}};
      if (drive_en && sh_en_d[idx_q]) digit_d[idx_q] = ~AN_OFF;
      dp_d     = drive_en ? ~(sh_dp_d[idx_q] & sh_en_d[idx_q]) : SEG_OFF;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q    <= '0;
         sh_val_q <= '0;
         sh_en_q  <= '0;
         sh_dp_q  <= '0;
         nibble_q <= '0;
         digit_q  <= {NDIG{AN_OFF}};
         dp_q     <= SEG_OFF;
         tick_q   <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         sh_val_q <= sh_val_d;
         sh_en_q  <= sh_en_d;
         sh_dp_q  <= sh_dp_d;
         nibble_q <= nibble_d;
         digit_q  <= digit_d;
         dp_q     <= dp_d;
         tick_q   <= snap;
      end
   end
   assign nibble     = nibble_q;
   assign digit      = digit_q;
   assign dp         = dp_q;
   assign frame_tick = tick_q;
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed plus randomized bench against a frame-position reference model
module tb_display_scan;
   localparam int NDIG = 8, PRESCALE = 8, BLANK_CYC = 2, FRAME = NDIG * PRESCALE;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [31:0] value = 32'h0;
   logic [7:0] digit_en = 8'h0, dp_in = 8'h0;
   logic [3:0] nibble;
   logic [7:0] digit;
   logic dp, frame_tick;
   int checks = 0, errors = 0;
   int pos = 0;
   logic [31:0] m_val = 32'h0;
   logic [7:0] m_en = 8'h0, m_dp = 8'h0;
   logic [3:0] prev_nib = 4'h0;
   display_scan #(.NDIG(NDIG), .PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .digit_en   (digit_en),
      .dp_in      (dp_in),
      .nibble     (nibble),
      .digit      (digit),
      .dp         (dp),
      .frame_tick (frame_tick)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // Model: outputs after the n-th edge since release reflect frame position n,
   // i.e. slot n/PRESCALE and cycle-in-slot n%PRESCALE of a FRAME-cycle frame.
   task automatic step();
      logic [7:0] ed;
      logic [3:0] enib;
      logic edp, etick;
      int p, s, c;
      @(posedge clk);
      if (!rst_n) begin
         pos = 0;
         ed = 8'hFF; edp = 1'b1; enib = 4'h0; etick = 1'b0;
      end else begin
         p = pos % FRAME;
         s = p / PRESCALE;
         c = p % PRESCALE;
         if (p == 0) begin
            m_val = value; m_en = digit_en; m_dp = dp_in;
         end
         etick = (p == 0);
         enib = 4'((m_val >> (4 * s)) & 32'hF);
         ed = 8'hFF;
         if (c >= BLANK_CYC && m_en[s]) ed[s] = 1'b0;
         edp = !(c >= BLANK_CYC && m_en[s] && m_dp[s]);
         pos++;
      end
      #1;
      chk("digit", 32'(digit), 32'(ed));
      chk("dp", 32'(dp), 32'(edp));
      chk("nibble", 32'(nibble), 32'(enib));
      chk("frame_tick", 32'(frame_tick), 32'(etick));
      chk("one_low", 32'($countones(~digit) <= 1), 32'd1);
      if (nibble !== prev_nib) chk("nib_blank", 32'(digit), 32'hFF);
      prev_nib = nibble;
   endtask
   task automatic run(input int n);
      repeat (n) step();
   endtask
   task automatic until_pos(input int target);
      for (int i = 0; i < FRAME && (pos % FRAME) != target; i++) step();
      chk("reach_pos", 32'(pos % FRAME), 32'(target));
   endtask
   initial begin
      value = 32'h12345678; digit_en = 8'hFF; dp_in = 8'h00; rst_n = 1'b0;
      run(3);
      rst_n = 1'b1;
      run(2 * FRAME);
      digit_en = 8'h0F;
      run(2 * FRAME);
      digit_en = 8'hFF; dp_in = 8'h04;
      run(2 * FRAME);
      until_pos(3 * PRESCALE + 3);
      value = 32'hDEADBEEF;
      run(100);
      until_pos(5 * PRESCALE + 4);
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      run(80);
      for (int i = 0; i < 640; i++) begin
         if ($urandom_range(0, 39) == 0) value = $urandom;
         if ($urandom_range(0, 39) == 0) digit_en = 8'($urandom);
         if ($urandom_range(0, 39) == 0) dp_in = 8'($urandom);
         rst_n = ($urandom_range(0, 299) != 0);
         step();
      end
      rst_n = 1'b1;
      run(FRAME);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
